// File: rtl/axi_regfile_gen2_pkg.sv
// axi_regfile_gen2_pkg: shared response codes, FSM state types and register-mode decode
package axi_regfile_gen2_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam int IDX_W    = 10;
   localparam int MAX_REGS = 2 ** IDX_W;
   typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
   typedef enum logic [1:0] {RW, RO, W1C} mode_t;
   // RO wins over W1C when both mask bits are set
   function automatic mode_t reg_mode(input logic [IDX_W-1:0] idx,
                                      input logic [MAX_REGS-1:0] ro_mask,
                                      input logic [MAX_REGS-1:0] w1c_mask);
      return ro_mask[idx] ? RO : w1c_mask[idx] ? W1C : RW;
   endfunction
endpackage

// File: rtl/axi_regfile_gen2_bank.sv
// axi_regfile_gen2_bank: register storage with RW/RO/W1C modes, byte strobes and write pulses
// Ports: clk/rst; wr_en/wr_idx/wr_data/wr_strb from the write FSM (wr_en is one cycle);
// slv_set sticky sets for W1C; slv_reg contents (RO slots 0); slv_wr_pulse written-bit mask.
module axi_regfile_gen2_bank
   import axi_regfile_gen2_pkg::*;
#(
   parameter int DW = 32,
   parameter int LOG2_NREGS = 4,
   parameter int NREGS_USED = 16,
   parameter logic [NREGS_USED-1:0] RO_MASK = '0,
   parameter logic [NREGS_USED-1:0] W1C_MASK = '0,
   parameter logic [NREGS_USED*DW-1:0] RESET_VAL = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic wr_en,
   input  logic [LOG2_NREGS-1:0] wr_idx,
   input  logic [DW-1:0] wr_data,
   input  logic [DW/8-1:0] wr_strb,
   input  logic [NREGS_USED*DW-1:0] slv_set,
   output logic [NREGS_USED*DW-1:0] slv_reg,
   output logic [NREGS_USED*DW-1:0] slv_wr_pulse
);
   logic [DW-1:0] strb_mask;
   logic unused_set;
   assign unused_set = ^slv_set;
   always_comb begin
      strb_mask = '0;
      for (int b = 0; b < DW / 8; b++) strb_mask[b*8 +: 8] = {8{wr_strb[b]}};
   end
   genvar r;
   for (r = 0; r < NREGS_USED; r++) begin : g_reg
      localparam mode_t M = reg_mode(IDX_W'(r), MAX_REGS'(RO_MASK), MAX_REGS'(W1C_MASK));
      if (M == RO) begin : g_ro
         assign slv_reg[r*DW +: DW] = '0;
         assign slv_wr_pulse[r*DW +: DW] = '0;
      end else begin : g_rw
         logic hit;
         logic [DW-1:0] q, p;
         assign hit = wr_en && wr_idx == LOG2_NREGS'(r);
         // W1C: the OR of slv_set comes last so a set beats a clear on the same bit
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               q <= RESET_VAL[r*DW +: DW];
               p <= '0;
            end else begin
               q <= M == W1C ? (q & ~(hit ? wr_data & strb_mask : '0)) | slv_set[r*DW +: DW]
                             : hit ? (q & ~strb_mask) | (wr_data & strb_mask) : q;
               p <= hit ? strb_mask : '0;
            end
         assign slv_reg[r*DW +: DW] = q;
         assign slv_wr_pulse[r*DW +: DW] = p;
      end
   end
endmodule

// File: rtl/axi_regfile_gen2.sv
// axi_regfile_gen2: AXI4-Lite slave register file with RW/RO/W1C registers
// Ports: S_AXI_* AXI4-Lite slave (AWPROT/ARPROT ignored); slv_reg register contents;
// slv_read RO sources; slv_set W1C sticky sets; slv_wr_pulse / slv_rd_pulse access strobes.
module axi_regfile_gen2
   import axi_regfile_gen2_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int LOG2_NREGS = 4,
   parameter int NREGS_USED = 16,
   parameter logic [NREGS_USED-1:0] RO_MASK = '0,
   parameter logic [NREGS_USED-1:0] W1C_MASK = '0,
   parameter logic [NREGS_USED*C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = '0,
   parameter int C_S_AXI_ADDR_WIDTH = LOG2_NREGS + $clog2(C_S_AXI_DATA_WIDTH / 8)
) (
   input  logic S_AXI_ACLK,
   input  logic S_AXI_ARESET,
   output logic [NREGS_USED*C_S_AXI_DATA_WIDTH-1:0] slv_reg,
   input  logic [NREGS_USED*C_S_AXI_DATA_WIDTH-1:0] slv_read,
   input  logic [NREGS_USED*C_S_AXI_DATA_WIDTH-1:0] slv_set,
   output logic [NREGS_USED*C_S_AXI_DATA_WIDTH-1:0] slv_wr_pulse,
   output logic [NREGS_USED-1:0] slv_rd_pulse,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0] S_AXI_AWPROT,
   input  logic S_AXI_AWVALID,
   output logic S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic S_AXI_WVALID,
   output logic S_AXI_WREADY,
   output logic [1:0] S_AXI_BRESP,
   output logic S_AXI_BVALID,
   input  logic S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0] S_AXI_ARPROT,
   input  logic S_AXI_ARVALID,
   output logic S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0] S_AXI_RRESP,
   output logic S_AXI_RVALID,
   input  logic S_AXI_RREADY
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int LSB = $clog2(DW / 8);
   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;
   logic live, aw_done, w_done, aw_hs, w_hs, ar_hs, wr_map, rd_map, unused;
   logic [LOG2_NREGS-1:0] aw_idx, rd_idx;
   logic [DW-1:0] w_data, rd_val;
   logic [DW/8-1:0] w_strb;
   logic [DW-1:0] reg_arr [NREGS_USED];
   logic [DW-1:0] ro_arr [NREGS_USED];
   assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};
   // live keeps every READY low while reset is asserted and until the first edge after it
   assign S_AXI_AWREADY = live && wr_state == WR_IDLE && !aw_done;
   assign S_AXI_WREADY  = live && wr_state == WR_IDLE && !w_done;
   assign S_AXI_ARREADY = live && rd_state == RD_IDLE;
   assign S_AXI_BVALID  = wr_state == WR_RESP;
   assign S_AXI_RVALID  = rd_state == RD_RESP;
   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
   assign rd_idx = S_AXI_ARADDR[AW-1:LSB];
   assign wr_map = 32'(aw_idx) < NREGS_USED;
   assign rd_map = 32'(rd_idx) < NREGS_USED;
   genvar r;
   for (r = 0; r < NREGS_USED; r++) begin : g_arr
      assign reg_arr[r] = slv_reg[r*DW +: DW];
      assign ro_arr[r]  = slv_read[r*DW +: DW];
   end
   always_comb begin
      wr_next = wr_state == WR_IDLE ? (((aw_done || aw_hs) && (w_done || w_hs)) ? WR_EXEC : WR_IDLE)
              : wr_state == WR_EXEC ? WR_RESP
              : S_AXI_BREADY ? WR_IDLE : WR_RESP;
      rd_next = rd_state == RD_IDLE ? (ar_hs ? RD_RESP : RD_IDLE)
              : S_AXI_RREADY ? RD_IDLE : RD_RESP;
      rd_val = !rd_map ? '0
             : reg_mode(IDX_W'(rd_idx), MAX_REGS'(RO_MASK), MAX_REGS'(W1C_MASK)) == RO ? ro_arr[rd_idx]
             : reg_arr[rd_idx];
   end
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
      if (S_AXI_ARESET) begin
         wr_state <= WR_IDLE;
         rd_state <= RD_IDLE;
         live <= 1'b0;
      end else begin
         wr_state <= wr_next;
         rd_state <= rd_next;
         live <= 1'b1;
      end
   // AW and W captures are held independently until both are present
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
      if (S_AXI_ARESET) begin
         aw_done <= 1'b0;
         w_done <= 1'b0;
         aw_idx <= '0;
         w_data <= '0;
         w_strb <= '0;
         S_AXI_BRESP <= RESP_OKAY;
         S_AXI_RDATA <= '0;
         S_AXI_RRESP <= RESP_OKAY;
         slv_rd_pulse <= '0;
      end else begin
         aw_done <= wr_next == WR_EXEC ? 1'b0 : aw_done || aw_hs;
         w_done <= wr_next == WR_EXEC ? 1'b0 : w_done || w_hs;
         if (aw_hs) aw_idx <= S_AXI_AWADDR[AW-1:LSB];
         if (w_hs) begin
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         if (wr_state == WR_EXEC) S_AXI_BRESP <= wr_map ? RESP_OKAY : RESP_SLVERR;
         if (ar_hs) begin
            S_AXI_RDATA <= rd_val;
            S_AXI_RRESP <= rd_map ? RESP_OKAY : RESP_SLVERR;
         end
         slv_rd_pulse <= ar_hs && rd_map ? NREGS_USED'(1) << rd_idx : '0;
      end
   axi_regfile_gen2_bank #(
      .DW(DW), .LOG2_NREGS(LOG2_NREGS), .NREGS_USED(NREGS_USED),
      .RO_MASK(RO_MASK), .W1C_MASK(W1C_MASK), .RESET_VAL(RESET_VAL)
   ) u_bank (
      .clk(S_AXI_ACLK),
      .rst(S_AXI_ARESET),
      .wr_en(wr_state == WR_EXEC),
      .wr_idx(aw_idx),
      .wr_data(w_data),
      .wr_strb(w_strb),
      .slv_set(slv_set),
      .slv_reg(slv_reg),
      .slv_wr_pulse(slv_wr_pulse)
   );
endmodule

// File: tb/tb_axi_regfile_gen2.sv
// tb_axi_regfile_gen2: directed scoreboard bench for axi_regfile_gen2
module tb_axi_regfile_gen2;
   localparam int NR = 10;
   localparam int DW = 32;
   localparam int AW = 6;
   localparam logic [NR-1:0] RO_M  = 10'b0000000100;
   localparam logic [NR-1:0] W1C_M = 10'b0000100000;
   localparam logic [NR*DW-1:0] RV = {32'h0, 32'h0, 32'h12345678, 32'h0, 32'h0,
                                      32'h0, 32'hCAFE0003, 32'h0, 32'h0, 32'hA5A50000};
   logic clk = 1'b0;
   logic rst;
   logic [NR*DW-1:0] slv_reg, slv_read, slv_set, slv_wr_pulse;
   logic [NR-1:0] slv_rd_pulse;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0] awprot, arprot;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [3:0] wstrb;
   logic [1:0] bresp, rresp;
   int nvec = 0;
   int nfail = 0;
   logic [DW-1:0] mdl [NR];
   logic [1:0] bq [$];
   logic [33:0] rq [$];
   always #5 clk = ~clk;
   axi_regfile_gen2 #(
      .C_S_AXI_DATA_WIDTH(DW), .LOG2_NREGS(4), .NREGS_USED(NR),
      .RO_MASK(RO_M), .W1C_MASK(W1C_M), .RESET_VAL(RV)
   ) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .slv_reg(slv_reg), .slv_read(slv_read), .slv_set(slv_set),
      .slv_wr_pulse(slv_wr_pulse), .slv_rd_pulse(slv_rd_pulse),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
   );
   task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [NR*DW-1:0] exp_regs();
      logic [NR*DW-1:0] v;
      v = '0;
      for (int r = 0; r < NR; r++) v[r*DW +: DW] = RO_M[r] ? 32'h0 : mdl[r];
      return v;
   endfunction
   task automatic reset_model();
      for (int r = 0; r < NR; r++) mdl[r] = RV[r*DW +: DW];
   endtask
   task automatic do_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                           input int w_delay, input int b_delay, input logic [31:0] es);
      logic [31:0] m;
      logic [NR*DW-1:0] ep;
      bit awp, wp, awf, wf;
      int c;
      bit ok;
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
      ok = idx < NR;
      ep = '0;
      if (ok && !RO_M[idx]) begin
         ep[idx*DW +: DW] = m;
         mdl[idx] = W1C_M[idx] ? (mdl[idx] & ~(d & m)) | es : (mdl[idx] & ~m) | (d & m);
      end
      bq.push_back(ok ? 2'b00 : 2'b10);
      awp = 1; wp = 1; c = 0;
      while ((awp || wp) && c < 20) begin
         @(negedge clk);
         awvalid = awp;
         awaddr = AW'(idx * 4 + 3);
         wvalid = wp && c >= w_delay;
         wdata = d;
         wstrb = s;
         awf = awvalid && awready;
         wf = wvalid && wready;
         @(posedge clk);
         if (awf) awp = 0;
         if (wf) wp = 0;
         c++;
      end
      chk("wr_accept", {awp, wp}, 0);
      @(negedge clk);
      awvalid = 0;
      wvalid = 0;
      if (ok) slv_set[idx*DW +: DW] = es;
      chk("wr_exec_pulse", slv_wr_pulse, 0);
      chk("wr_exec_bvalid", bvalid, 0);
      @(negedge clk);
      slv_set = '0;
      chk("wr_pulse", slv_wr_pulse, ep);
      chk("wr_bvalid", bvalid, 1);
      chk("wr_regs", slv_reg, exp_regs());
      if (b_delay < 0) return;
      for (int k = 0; k < b_delay; k++) begin
         @(negedge clk);
         chk("b_hold_valid", bvalid, 1);
         chk("b_hold_resp", bresp, bq[0]);
         chk("b_hold_ready", {awready, wready}, 0);
         chk("b_hold_pulse", slv_wr_pulse, 0);
      end
      bready = 1;
      chk("bresp", bresp, bq.pop_front());
      @(posedge clk);
      @(negedge clk);
      bready = 0;
      chk("b_done", bvalid, 0);
      chk("wr_pulse_end", slv_wr_pulse, 0);
   endtask
   task automatic do_read(input int idx, input int rr_delay);
      logic [31:0] ed;
      logic [NR-1:0] ep;
      bit arp, f;
      int c;
      ed = idx >= NR ? 32'h0 : RO_M[idx] ? slv_read[idx*DW +: DW] : mdl[idx];
      ep = idx < NR ? NR'(1) << idx : '0;
      rq.push_back({idx < NR ? 2'b00 : 2'b10, ed});
      arp = 1; c = 0;
      while (arp && c < 20) begin
         @(negedge clk);
         arvalid = 1;
         araddr = AW'(idx * 4 + 1);
         f = arvalid && arready;
         @(posedge clk);
         if (f) arp = 0;
         c++;
      end
      chk("rd_accept", arp, 0);
      @(negedge clk);
      arvalid = 0;
      chk("rd_rvalid", rvalid, 1);
      chk("rd_pulse", slv_rd_pulse, ep);
      if (rr_delay < 0) return;
      for (int k = 0; k < rr_delay; k++) begin
         @(negedge clk);
         chk("r_hold_data", rdata, rq[0][31:0]);
         chk("r_hold_resp", rresp, rq[0][33:32]);
         chk("r_hold_flags", {rvalid, arready}, 2'b10);
         chk("r_hold_pulse", slv_rd_pulse, 0);
      end
      rready = 1;
      chk("rdata", rdata, rq[0][31:0]);
      chk("rresp", rresp, rq.pop_front() >> 32);
      @(posedge clk);
      @(negedge clk);
      rready = 0;
      chk("r_done", rvalid, 0);
      chk("rd_pulse_end", slv_rd_pulse, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = '0; araddr = '0; awprot = 3'b010; arprot = 3'b101; wdata = '0; wstrb = '0;
      slv_set = '0;
      for (int r = 0; r < NR; r++) slv_read[r*DW +: DW] = 32'h0BAD0000 | r;
      slv_read[2*DW +: DW] = 32'h55AA55AA;
      reset_model();
      repeat (3) @(negedge clk);
      chk("rst_ready", {awready, wready, arready}, 0);
      chk("rst_valid", {bvalid, rvalid}, 0);
      chk("rst_rdata", {rdata, rresp, bresp}, 0);
      chk("rst_regs", slv_reg, exp_regs());
      chk("rst_pulses", {slv_wr_pulse, slv_rd_pulse}, 0);
      rst = 0;
      // RW write, W two cycles after AW
      do_write(3, 32'hDEADBEEF, 4'hF, 2, 0, 0);
      chk("t1_reg3", slv_reg[3*DW +: DW], 32'hDEADBEEF);
      do_read(3, 0);
      // byte-strobe write, AW and W together
      do_write(3, 32'h11223344, 4'hF, 0, 0, 0);
      do_write(3, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
      chk("t2_reg3", slv_reg[3*DW +: DW], 32'h11BB33DD);
      // W1C: hardware set, then clear by write
      @(negedge clk);
      slv_set[5*DW +: DW] = 32'h0000000F;
      @(negedge clk);
      slv_set = '0;
      mdl[5] = mdl[5] | 32'h0000000F;
      chk("t3_set", slv_reg[5*DW +: DW], 32'h0000000F);
      do_write(5, 32'h00000005, 4'hF, 1, 0, 0);
      chk("t3_clr", slv_reg[5*DW +: DW], 32'h0000000A);
      @(negedge clk);
      slv_set[5*DW +: DW] = 32'h0000000F;
      @(negedge clk);
      slv_set = '0;
      mdl[5] = mdl[5] | 32'h0000000F;
      do_write(5, 32'h00000005, 4'hF, 0, 0, 32'h00000001);
      chk("t3_setwins", slv_reg[5*DW +: DW], 32'h0000000B);
      do_read(5, 0);
      // unmapped index
      do_read(12, 0);
      do_write(12, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      chk("t4_regs", slv_reg, exp_regs());
      // RO register
      do_write(2, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      chk("t5_ro", slv_reg[2*DW +: DW], 32'h0);
      do_read(2, 0);
      // backpressure on both response channels
      do_write(7, 32'h87654321, 4'hF, 0, 5, 0);
      do_read(7, 5);
      // reset in the middle of outstanding responses
      do_write(3, 32'h0F0F0F0F, 4'hF, 0, -1, 0);
      do_read(3, -1);
      @(negedge clk);
      rst = 1;
      #1;
      reset_model();
      bq.delete();
      rq.delete();
      chk("t6_rst_valid", {bvalid, rvalid}, 0);
      chk("t6_rst_regs", slv_reg, exp_regs());
      @(negedge clk);
      chk("t6_rst_ready", {awready, wready, arready}, 0);
      rst = 0;
      do_write(1, 32'h01020304, 4'b1000, 0, 0, 0);
      chk("t7_reg1", slv_reg[1*DW +: DW], 32'h01000000);
      do_read(0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
